// File: rtl/display_pkg.sv
// Shared constants for the VGA display path: default 640x480@60 timing,
// display mode encodings and the colour-bar code helper.
package display_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam logic [1:0] MODE_BARS      = 2'd0;
    localparam logic [1:0] MODE_BARS_TEXT = 2'd1;
    localparam logic [1:0] MODE_BLACK     = 2'd2;
    localparam logic [1:0] MODE_TEXT      = 2'd3;

    // Colour code for bar k (mod 8): bit2 = green, bit1 = red, bit0 = blue.
    function automatic logic [2:0] bar_code(input logic [2:0] k);
        return 3'd7 - k;
    endfunction

endpackage

// File: rtl/hex_font_rom.sv
// 8x8 glyph table for hex digits 0-F; row 0 is the top row, bit 7 the
// leftmost pixel.
module hex_font_rom
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic [2:0] row,
    output logic [7:0] glyph_row
);

    logic [63:0] glyph_s;

    // Whole glyph per nibble, top row in the most significant byte.
    always_comb begin
        case (nibble)
            4'h0:    glyph_s = 64'h3C66_6E76_6666_3C00;
            4'h1:    glyph_s = 64'h1838_1818_1818_7E00;
            4'h2:    glyph_s = 64'h3C66_060C_3060_7E00;
            4'h3:    glyph_s = 64'h3C66_061C_0666_3C00;
            4'h4:    glyph_s = 64'h0C1C_3C6C_7E0C_0C00;
            4'h5:    glyph_s = 64'h7E60_7C06_0666_3C00;
            4'h6:    glyph_s = 64'h3C60_7C66_6666_3C00;
            4'h7:    glyph_s = 64'h7E06_0C18_3030_3000;
            4'h8:    glyph_s = 64'h3C66_663C_6666_3C00;
            4'h9:    glyph_s = 64'h3C66_663E_060C_3800;
            4'hA:    glyph_s = 64'h183C_6666_7E66_6600;
            4'hB:    glyph_s = 64'h7C66_667C_6666_7C00;
            4'hC:    glyph_s = 64'h3C66_6060_6066_3C00;
            4'hD:    glyph_s = 64'h786C_6666_666C_7800;
            4'hE:    glyph_s = 64'h7E60_607C_6060_7E00;
            4'hF:    glyph_s = 64'h7E60_607C_6060_6000;
            default: glyph_s = 64'h0;
        endcase
    end

    assign glyph_row = glyph_s[{3'd7 - row, 3'b000} +: 8];

endmodule

// File: rtl/display_gen.sv
// VGA timing generator with colour bars, hex debug-word overlay and a
// per-frame mode snapshot; fixed two-cycle latency from counters to pins.
module display_gen
    import display_pkg::*;
#(
    parameter int COLOR_BITS = 4,
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit SYNC_POL   = 1'b0,
    parameter int NBARS      = 8,
    parameter int DBG_WORDS  = 2,
    parameter int TEXT_X     = 8,
    parameter int TEXT_Y     = 8
) (
    input  logic                                              vga_clk,
    input  logic                                              rst,
    input  logic [1:0]                                        mode,
    input  logic [32*DBG_WORDS-1:0]                           dbg,
    output logic                                              vga_hs,
    output logic                                              vga_vs,
    output logic                                              vga_de,
    output logic [COLOR_BITS-1:0]                             vga_r,
    output logic [COLOR_BITS-1:0]                             vga_g,
    output logic [COLOR_BITS-1:0]                             vga_b,
    output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]      x_cnt,
    output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]      y_cnt,
    output logic                                              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW      = $clog2(H_TOTAL);
    localparam int YW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / NBARS;
    localparam int BPW     = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int KW      = $clog2(NBARS + 1);
    localparam int HS_LO   = H_ACTIVE + H_FP;
    localparam int HS_HI   = HS_LO + H_SYNC;
    localparam int VS_LO   = V_ACTIVE + V_FP;
    localparam int VS_HI   = VS_LO + V_SYNC;
    localparam logic [COLOR_BITS-1:0] ONES = {COLOR_BITS{1'b1}};

    logic [XW-1:0]              x_q, x_d;
    logic [YW-1:0]              y_q, y_d;
    logic [BPW-1:0]             bar_pix_q, bar_pix_d;
    logic [KW-1:0]              bar_k_q, bar_k_d;
    logic [1:0]                 mode_q, mode_d;
    logic [32*DBG_WORDS-1:0]    snap_q, snap_d;

    logic [31:0]                x_w, y_w, dy_w, word_s;
    logic [5:0]                 dx_s;
    logic [3:0]                 nib_s;
    logic [32*DBG_WORDS-1:0]    src_s;
    logic                       act_s, text_s;

    logic [2:0]                 bark1_q, bark1_d, bitsel1_q, bitsel1_d;
    logic [6:0]                 gaddr1_q, gaddr1_d;
    logic                       text1_q, text1_d;
    logic                       hs1_q, hs1_d, vs1_q, vs1_d, de1_q, de1_d;
    logic                       hs2_q, vs2_q, de2_q;
    logic [COLOR_BITS-1:0]      r_q, r_d, g_q, g_d, b_q, b_d;

    logic [7:0]                 glyph_s;
    logic [2:0]                 code_s;
    logic [COLOR_BITS-1:0]      bar_r_s, bar_g_s, bar_b_s, txt_s;

    assign frame_start = (x_q == '0) && (y_q == '0);
    assign x_cnt       = x_q;
    assign y_cnt       = y_q;
    assign x_w         = 32'(x_q);
    assign y_w         = 32'(y_q);

    // Raster counters, bar sub-counter and frame snapshot next-state.
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        bar_pix_d = bar_pix_q;
        bar_k_d   = bar_k_q;
        if (x_q == XW'(H_TOTAL - 1)) begin
            x_d       = '0;
            bar_pix_d = '0;
            bar_k_d   = '0;
            if (y_q == YW'(V_TOTAL - 1)) begin
                y_d = '0;
            end else begin
                y_d = y_q + YW'(1);
            end
        end else begin
            x_d = x_q + XW'(1);
            if (bar_pix_q == BPW'(BAR_W - 1)) begin
                bar_pix_d = '0;
                bar_k_d   = bar_k_q + KW'(1);
            end else begin
                bar_pix_d = bar_pix_q + BPW'(1);
            end
        end
        if (frame_start) begin
            mode_d = mode;
            snap_d = dbg;
        end else begin
            mode_d = mode_q;
            snap_d = snap_q;
        end
    end

    // Stage 0 -> 1: region decode and glyph address; the snapshot is
    // bypassed on the frame-start cycle so pixel (0,0) sees the new words.
    always_comb begin
        dx_s   = 6'(x_w - 32'(TEXT_X));
        dy_w   = y_w - 32'(TEXT_Y);
        act_s  = (x_w < 32'(H_ACTIVE)) && (y_w < 32'(V_ACTIVE));
        text_s = act_s && (x_w >= 32'(TEXT_X)) && (x_w < 32'(TEXT_X + 64)) &&
                 (y_w >= 32'(TEXT_Y)) && (y_w < 32'(TEXT_Y + 8*DBG_WORDS));
        src_s  = frame_start ? dbg : snap_q;
        word_s = '0;
        for (int i = 0; i < DBG_WORDS; i++) begin
            if (dy_w[31:3] == 29'(i)) begin
                word_s = src_s[i*32 +: 32];
            end else begin
                word_s = word_s;
            end
        end
        nib_s     = word_s[{3'd7 - dx_s[5:3], 2'b00} +: 4];
        bark1_d   = 3'(bar_k_q);
        text1_d   = text_s;
        gaddr1_d  = {nib_s, dy_w[2:0]};
        bitsel1_d = 3'd7 - dx_s[2:0];
        hs1_d     = ((x_w >= 32'(HS_LO)) && (x_w < 32'(HS_HI))) ? SYNC_POL : ~SYNC_POL;
        vs1_d     = ((y_w >= 32'(VS_LO)) && (y_w < 32'(VS_HI))) ? SYNC_POL : ~SYNC_POL;
        de1_d     = act_s;
    end

    hex_font_rom u_font (
        .nibble    (gaddr1_q[6:3]),
        .row       (gaddr1_q[2:0]),
        .glyph_row (glyph_s)
    );

    // Stage 1 -> 2: colour selection by snapshotted mode, blanked outside de.
    always_comb begin
        code_s  = bar_code(bark1_q);
        bar_r_s = code_s[1] ? ONES : '0;
        bar_g_s = code_s[2] ? ONES : '0;
        bar_b_s = code_s[0] ? ONES : '0;
        txt_s   = glyph_s[bitsel1_q] ? ONES : '0;
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (de1_q) begin
            case (mode_q)
                MODE_BARS: begin
                    r_d = bar_r_s; g_d = bar_g_s; b_d = bar_b_s;
                end
                MODE_BARS_TEXT: begin
                    if (text1_q) begin
                        r_d = txt_s; g_d = txt_s; b_d = txt_s;
                    end else begin
                        r_d = bar_r_s; g_d = bar_g_s; b_d = bar_b_s;
                    end
                end
                MODE_TEXT: begin
                    if (text1_q) begin
                        r_d = txt_s; g_d = txt_s; b_d = txt_s;
                    end else begin
                        r_d = '0; g_d = '0; b_d = '0;
                    end
                end
                default: begin
                    r_d = '0; g_d = '0; b_d = '0;
                end
            endcase
        end else begin
            r_d = '0; g_d = '0; b_d = '0;
        end
    end

    // All state: counters, snapshot and both pipeline stages.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            x_q       <= '0;
            y_q       <= '0;
            bar_pix_q <= '0;
            bar_k_q   <= '0;
            mode_q    <= MODE_BARS;
            snap_q    <= '0;
            bark1_q   <= 3'd0;
            text1_q   <= 1'b0;
            gaddr1_q  <= 7'd0;
            bitsel1_q <= 3'd0;
            hs1_q     <= ~SYNC_POL;
            vs1_q     <= ~SYNC_POL;
            de1_q     <= 1'b0;
            hs2_q     <= ~SYNC_POL;
            vs2_q     <= ~SYNC_POL;
            de2_q     <= 1'b0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            bar_pix_q <= bar_pix_d;
            bar_k_q   <= bar_k_d;
            mode_q    <= mode_d;
            snap_q    <= snap_d;
            bark1_q   <= bark1_d;
            text1_q   <= text1_d;
            gaddr1_q  <= gaddr1_d;
            bitsel1_q <= bitsel1_d;
            hs1_q     <= hs1_d;
            vs1_q     <= vs1_d;
            de1_q     <= de1_d;
            hs2_q     <= hs1_q;
            vs2_q     <= vs1_q;
            de2_q     <= de1_q;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
        end
    end

    assign vga_hs = hs2_q;
    assign vga_vs = vs2_q;
    assign vga_de = de2_q;
    assign vga_r  = r_q;
    assign vga_g  = g_q;
    assign vga_b  = b_q;

endmodule
